// File: rtl/vga_timing_pkg.sv
// Shared timing constants, parameter record and helpers for the VGA timing generator.
// Defaults describe the 784x510 camera-locked VGA raster.
package vga_timing_pkg;

  localparam int unsigned VGA_PIX_DIV      = 2;
  localparam int unsigned VGA_H_TOTAL      = 784;
  localparam int unsigned VGA_H_SYNC       = 96;
  localparam int unsigned VGA_H_VIS_START  = 134;
  localparam int unsigned VGA_H_VIS        = 642;
  localparam int unsigned VGA_V_TOTAL      = 510;
  localparam int unsigned VGA_V_SYNC_START = 500;
  localparam int unsigned VGA_V_SYNC       = 2;
  localparam int unsigned VGA_V_VIS_START  = 17;
  localparam int unsigned VGA_V_VIS        = 481;
  localparam int unsigned VGA_H_W          = 10;
  localparam int unsigned VGA_V_W          = 9;

  typedef struct packed {
    int unsigned pix_div;
    int unsigned h_total;
    int unsigned h_sync;
    int unsigned h_vis_start;
    int unsigned h_vis;
    int unsigned v_total;
    int unsigned v_sync_start;
    int unsigned v_sync;
    int unsigned v_vis_start;
    int unsigned v_vis;
  } vga_timing_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping counter for one raster axis: counts 0..TOTAL-1 on en_i,
// synchronous clear wins over counting, wrap_o flags the enabled terminal count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W     = VGA_H_W,
  parameter int unsigned TOTAL = VGA_H_TOTAL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == W'(TOTAL - 1));
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel divider, pixel/line counters and registered
// sync/visible strobes, optionally phase-locked to camera sync edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV      = VGA_PIX_DIV,
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned H_SYNC       = VGA_H_SYNC,
  parameter int unsigned H_VIS_START  = VGA_H_VIS_START,
  parameter int unsigned H_VIS        = VGA_H_VIS,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
  parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
  parameter int unsigned V_SYNC       = VGA_V_SYNC,
  parameter int unsigned V_VIS_START  = VGA_V_VIS_START,
  parameter int unsigned V_VIS        = VGA_V_VIS,
  parameter logic        H_POL        = 1'b0,
  parameter logic        V_POL        = 1'b0,
  parameter int unsigned H_W          = VGA_H_W,
  parameter int unsigned V_W          = VGA_V_W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           LockEn,
  input  logic           CamHsync_EDGE,
  input  logic           CamVsync_EDGE,
  output logic           PixEnb,
  output logic [H_W-1:0] PixCount,
  output logic [V_W-1:0] LineCount,
  output logic [H_W-1:0] VisX,
  output logic [V_W-1:0] VisY,
  output logic           Visible,
  output logic           Hsync,
  output logic           Vsync,
  output logic           HsyncEnd,
  output logic           FrameStart,
  output logic           OddFrame
);

  localparam vga_timing_t Cfg = '{
    pix_div:      PIX_DIV,
    h_total:      H_TOTAL,
    h_sync:       H_SYNC,
    h_vis_start:  H_VIS_START,
    h_vis:        H_VIS,
    v_total:      V_TOTAL,
    v_sync_start: V_SYNC_START,
    v_sync:       V_SYNC,
    v_vis_start:  V_VIS_START,
    v_vis:        V_VIS
  };
  localparam int unsigned DivW = (PIX_DIV > 1) ? clog2(PIX_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic            hs_resync, vs_resync;
  logic            h_wrap, v_wrap, line_en;
  logic [H_W-1:0]  pix_cnt;
  logic [V_W-1:0]  line_cnt;
  logic            h_sync_act, v_sync_act, h_vis, v_vis;

  logic           hsync_q, hsync_d, vsync_q, vsync_d, visible_q, visible_d;
  logic [H_W-1:0] vis_x_q, vis_x_d;
  logic [V_W-1:0] vis_y_q, vis_y_d;
  logic           hsync_end_q, hsync_end_d, frame_start_q, frame_start_d;
  logic           odd_frame_q, odd_frame_d;

  assign hs_resync = LockEn & CamHsync_EDGE;
  assign vs_resync = LockEn & CamVsync_EDGE;
  assign PixEnb    = (div_q == DivW'(Cfg.pix_div - 1));
  // A camera line edge holds the line counter so the forced pixel clear never advances a line.
  assign line_en   = h_wrap & ~hs_resync;

  always_comb begin
    div_d = PixEnb ? '0 : div_q + DivW'(1);
    if (hs_resync) begin
      div_d = '0;
    end
  end

  vga_axis_counter #(
    .W     (H_W),
    .TOTAL (Cfg.h_total)
  ) u_h_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (PixEnb),
    .clr_i  (hs_resync),
    .cnt_o  (pix_cnt),
    .wrap_o (h_wrap)
  );

  vga_axis_counter #(
    .W     (V_W),
    .TOTAL (Cfg.v_total)
  ) u_v_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (line_en),
    .clr_i  (vs_resync),
    .cnt_o  (line_cnt),
    .wrap_o (v_wrap)
  );

  always_comb begin
    h_sync_act = 32'(pix_cnt) < Cfg.h_sync;
    v_sync_act = (32'(line_cnt) >= Cfg.v_sync_start) &&
                 (32'(line_cnt) < Cfg.v_sync_start + Cfg.v_sync);
    h_vis      = (32'(pix_cnt) >= Cfg.h_vis_start) &&
                 (32'(pix_cnt) < Cfg.h_vis_start + Cfg.h_vis);
    v_vis      = (32'(line_cnt) >= Cfg.v_vis_start) &&
                 (32'(line_cnt) < Cfg.v_vis_start + Cfg.v_vis);
  end

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    visible_d = visible_q;
    vis_x_d   = vis_x_q;
    vis_y_d   = vis_y_q;
    if (PixEnb) begin
      hsync_d   = h_sync_act ? H_POL : ~H_POL;
      vsync_d   = v_sync_act ? V_POL : ~V_POL;
      visible_d = h_vis & v_vis;
      vis_x_d   = (h_vis & v_vis) ? pix_cnt - H_W'(Cfg.h_vis_start) : '0;
      vis_y_d   = (h_vis & v_vis) ? line_cnt - V_W'(Cfg.v_vis_start) : '0;
    end
    hsync_end_d   = PixEnb && (32'(pix_cnt) == Cfg.h_sync);
    frame_start_d = v_wrap & ~vs_resync;
    odd_frame_d   = odd_frame_q;
    if (vs_resync) begin
      odd_frame_d = 1'b1;
    end else if (v_wrap) begin
      odd_frame_d = ~odd_frame_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q         <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      visible_q     <= 1'b0;
      vis_x_q       <= '0;
      vis_y_q       <= '0;
      hsync_end_q   <= 1'b0;
      frame_start_q <= 1'b0;
      odd_frame_q   <= 1'b1;
    end else begin
      div_q         <= div_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      vis_x_q       <= vis_x_d;
      vis_y_q       <= vis_y_d;
      hsync_end_q   <= hsync_end_d;
      frame_start_q <= frame_start_d;
      odd_frame_q   <= odd_frame_d;
    end
  end

  assign PixCount   = pix_cnt;
  assign LineCount  = line_cnt;
  assign VisX       = vis_x_q;
  assign VisY       = vis_y_q;
  assign Visible    = visible_q;
  assign Hsync      = hsync_q;
  assign Vsync      = vsync_q;
  assign HsyncEnd   = hsync_end_q;
  assign FrameStart = frame_start_q;
  assign OddFrame   = odd_frame_q;

endmodule
